// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg : shared encodings for the ALU issue sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISS_LO  = 3'd1,
    ST_CAP_LO  = 3'd2,
    ST_ISS_HI  = 3'd3,
    ST_CAP_HI  = 3'd4,
    ST_ISS_FIX = 3'd5,
    ST_CAP_FIX = 3'd6
  } seq_state_t;

  // Opcodes packed as {log, hc[1:0], sc[2:0]}
  localparam logic [5:0] OP_ADD  = 6'b0_00_000;
  localparam logic [5:0] OP_SUB  = 6'b0_00_001;
  localparam logic [5:0] OP_COMP = 6'b0_00_101;

  localparam int ASTAT_AZ  = 0;
  localparam int ASTAT_AN  = 1;
  localparam int ASTAT_AC  = 2;
  localparam int ASTAT_AV  = 3;
  localparam int ASTAT_AVS = 4;

endpackage

`default_nettype wire

// File: rtl/alu_seq_dflag.sv
// ---------------------------------------------------------------------------
// alu_seq_dflag : double-precision AZ/AN/AV and write-back saturation mux
//                 (saturation only with ALU_SEQ_DBL_SAT_EN defined)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_dflag #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    is_sub,
  input  logic                    sat,
  input  logic                    xs,
  input  logic                    ys,
  input  logic [2*DATA_WIDTH-1:0] res,
  output logic                    az,
  output logic                    an,
  output logic                    av,
  output logic [2*DATA_WIDTH-1:0] wb
);

  localparam int DW2 = 2 * DATA_WIDTH;

  logic w_rs;

  assign w_rs = res[DW2-1];
  assign az   = (res == '0);
  assign an   = w_rs;
  assign av   = is_sub ? ((xs != ys) && (w_rs != xs)) : ((xs == ys) && (w_rs != xs));

`ifdef ALU_SEQ_DBL_SAT_EN
  // Overflow direction follows the sign of X: positive X can only overflow upward
  assign wb = (sat && av) ? (xs ? {1'b1, {(DW2-1){1'b0}}} : {1'b0, {(DW2-1){1'b1}}}) : res;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign wb = res;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl : ALU issue sequencer with double-precision ADD/SUB chaining
//                Optional macro: ALU_SEQ_DBL_SAT_EN (double-op saturation)
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps_seq_vld,
  output logic                    seq_ps_rdy,
  input  logic                    ps_seq_log,
  input  logic [1:0]              ps_seq_hc,
  input  logic [2:0]              ps_seq_sc,
  input  logic                    ps_seq_sat,
  input  logic                    ps_seq_dbl,
  input  logic [2*DATA_WIDTH-1:0] ps_seq_x,
  input  logic [2*DATA_WIDTH-1:0] ps_seq_y,
  input  logic                    ps_seq_clr_avs,
  output logic                    seq_alu_en,
  output logic                    seq_alu_log,
  output logic                    seq_alu_sat,
  output logic [1:0]              seq_alu_hc,
  output logic [2:0]              seq_alu_sc,
  output logic [DATA_WIDTH-1:0]   seq_xb_dtx,
  output logic [DATA_WIDTH-1:0]   seq_xb_dty,
  input  logic [DATA_WIDTH-1:0]   alu_seq_dt,
  input  logic                    alu_seq_az,
  input  logic                    alu_seq_an,
  input  logic                    alu_seq_ac,
  input  logic                    alu_seq_av,
  output logic                    seq_rf_we,
  output logic [2*DATA_WIDTH-1:0] seq_rf_dt,
  output logic [4:0]              seq_ps_astat
);

  localparam int DW  = DATA_WIDTH;
  localparam int DW2 = 2 * DATA_WIDTH;

  seq_state_t      r_state;
  logic            r_log;
  logic [1:0]      r_hc;
  logic [2:0]      r_sc;
  logic            r_sat;
  logic            r_dbl;
  logic            r_sub;
  logic [DW2-1:0]  r_x;
  logic [DW2-1:0]  r_y;
  logic [DW-1:0]   r_lo;
  logic            r_c0;
  logic            r_c1;

  logic [5:0]      w_op;
  logic            w_is_add;
  logic            w_is_sub;
  logic            w_is_comp;
  logic            w_fix_needed;
  logic            w_c1;
  logic            w_c2;
  logic            w_dac;
  logic            w_daz;
  logic            w_dan;
  logic            w_dav;
  logic [DW2-1:0]  w_dres;
  logic [DW2-1:0]  w_dwb;

  assign w_op      = {ps_seq_log, ps_seq_hc, ps_seq_sc};
  assign w_is_add  = (w_op == OP_ADD);
  assign w_is_sub  = (w_op == OP_SUB);
  assign w_is_comp = ({r_log, r_hc, r_sc} == OP_COMP);

  // ADD propagates a low-word carry; SUB propagates a low-word borrow (c0 = no-borrow)
  assign w_fix_needed = r_sub ? ~r_c0 : r_c0;
  assign w_c1   = (r_state == ST_CAP_HI) ? alu_seq_ac : r_c1;
  assign w_c2   = (r_state == ST_CAP_FIX) ? alu_seq_ac : r_sub;
  assign w_dac  = r_sub ? (w_c1 & w_c2) : (w_c1 | w_c2);
  assign w_dres = {alu_seq_dt, r_lo};

  alu_seq_dflag #(.DATA_WIDTH(DATA_WIDTH)) u_dflag (
    .is_sub (r_sub),
    .sat    (r_sat),
    .xs     (r_x[DW2-1]),
    .ys     (r_y[DW2-1]),
    .res    (w_dres),
    .az     (w_daz),
    .an     (w_dan),
    .av     (w_dav),
    .wb     (w_dwb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_log        <= 1'b0;
      r_hc         <= '0;
      r_sc         <= '0;
      r_sat        <= 1'b0;
      r_dbl        <= 1'b0;
      r_sub        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_lo         <= '0;
      r_c0         <= 1'b0;
      r_c1         <= 1'b0;
      seq_ps_rdy   <= 1'b1;
      seq_alu_en   <= 1'b0;
      seq_alu_log  <= 1'b0;
      seq_alu_sat  <= 1'b0;
      seq_alu_hc   <= '0;
      seq_alu_sc   <= '0;
      seq_xb_dtx   <= '0;
      seq_xb_dty   <= '0;
      seq_rf_we    <= 1'b0;
      seq_rf_dt    <= '0;
      seq_ps_astat <= '0;
    end else begin
      // ALU control is only non-zero in the cycle following an issue
      seq_alu_en  <= 1'b0;
      seq_alu_log <= 1'b0;
      seq_alu_sat <= 1'b0;
      seq_alu_hc  <= '0;
      seq_alu_sc  <= '0;
      seq_xb_dtx  <= '0;
      seq_xb_dty  <= '0;
      seq_rf_we   <= 1'b0;
      if (ps_seq_clr_avs) seq_ps_astat[ASTAT_AVS] <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (ps_seq_vld) begin
            r_log       <= ps_seq_log;
            r_hc        <= ps_seq_hc;
            r_sc        <= ps_seq_sc;
            r_sat       <= ps_seq_sat;
            r_dbl       <= ps_seq_dbl & (w_is_add | w_is_sub);
            r_sub       <= w_is_sub;
            r_x         <= ps_seq_x;
            r_y         <= ps_seq_y;
            seq_ps_rdy  <= 1'b0;
            seq_alu_en  <= 1'b1;
            seq_alu_log <= ps_seq_log;
            seq_alu_hc  <= ps_seq_hc;
            seq_alu_sc  <= ps_seq_sc;
            seq_alu_sat <= ps_seq_sat & ~(ps_seq_dbl & (w_is_add | w_is_sub));
            seq_xb_dtx  <= ps_seq_x[DW-1:0];
            seq_xb_dty  <= ps_seq_y[DW-1:0];
            r_state     <= ST_ISS_LO;
          end
        end
        ST_ISS_LO:  r_state <= ST_CAP_LO;
        ST_ISS_HI:  r_state <= ST_CAP_HI;
        ST_ISS_FIX: r_state <= ST_CAP_FIX;
        ST_CAP_LO: begin
          if (r_dbl) begin
            r_lo        <= alu_seq_dt;
            r_c0        <= alu_seq_ac;
            seq_alu_en  <= 1'b1;
            seq_alu_log <= r_log;
            seq_alu_hc  <= r_hc;
            seq_alu_sc  <= r_sc;
            seq_xb_dtx  <= r_x[DW2-1:DW];
            seq_xb_dty  <= r_y[DW2-1:DW];
            r_state     <= ST_ISS_HI;
          end else begin
            seq_ps_astat[ASTAT_AZ] <= alu_seq_az;
            seq_ps_astat[ASTAT_AN] <= alu_seq_an;
            seq_ps_astat[ASTAT_AC] <= alu_seq_ac;
            seq_ps_astat[ASTAT_AV] <= alu_seq_av;
            if (alu_seq_av) seq_ps_astat[ASTAT_AVS] <= 1'b1;
            if (!w_is_comp) begin
              seq_rf_we <= 1'b1;
              seq_rf_dt <= {{DW{1'b0}}, alu_seq_dt};
            end
            seq_ps_rdy <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_CAP_HI, ST_CAP_FIX: begin
          if (r_state == ST_CAP_HI) r_c1 <= alu_seq_ac;
          if ((r_state == ST_CAP_HI) && w_fix_needed) begin
            seq_alu_en  <= 1'b1;
            seq_alu_log <= r_log;
            seq_alu_hc  <= r_hc;
            seq_alu_sc  <= r_sc;
            seq_xb_dtx  <= alu_seq_dt;
            seq_xb_dty  <= {{(DW-1){1'b0}}, 1'b1};
            r_state     <= ST_ISS_FIX;
          end else begin
            seq_ps_astat[ASTAT_AZ] <= w_daz;
            seq_ps_astat[ASTAT_AN] <= w_dan;
            seq_ps_astat[ASTAT_AC] <= w_dac;
            seq_ps_astat[ASTAT_AV] <= w_dav;
            if (w_dav) seq_ps_astat[ASTAT_AVS] <= 1'b1;
            seq_rf_we  <= 1'b1;
            seq_rf_dt  <= w_dwb;
            seq_ps_rdy <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl : directed self-checking bench with a behavioural ALU
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps_seq_vld = 1'b0;
  logic        seq_ps_rdy;
  logic        ps_seq_log = 1'b0;
  logic [1:0]  ps_seq_hc = '0;
  logic [2:0]  ps_seq_sc = '0;
  logic        ps_seq_sat = 1'b0;
  logic        ps_seq_dbl = 1'b0;
  logic [31:0] ps_seq_x = '0;
  logic [31:0] ps_seq_y = '0;
  logic        ps_seq_clr_avs = 1'b0;
  logic        seq_alu_en, seq_alu_log, seq_alu_sat;
  logic [1:0]  seq_alu_hc;
  logic [2:0]  seq_alu_sc;
  logic [15:0] seq_xb_dtx, seq_xb_dty;
  logic [15:0] alu_seq_dt;
  logic        alu_seq_az, alu_seq_an, alu_seq_ac, alu_seq_av;
  logic        seq_rf_we;
  logic [31:0] seq_rf_dt;
  logic [4:0]  seq_ps_astat;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .ps_seq_vld(ps_seq_vld), .seq_ps_rdy(seq_ps_rdy),
    .ps_seq_log(ps_seq_log), .ps_seq_hc(ps_seq_hc), .ps_seq_sc(ps_seq_sc),
    .ps_seq_sat(ps_seq_sat), .ps_seq_dbl(ps_seq_dbl),
    .ps_seq_x(ps_seq_x), .ps_seq_y(ps_seq_y), .ps_seq_clr_avs(ps_seq_clr_avs),
    .seq_alu_en(seq_alu_en), .seq_alu_log(seq_alu_log), .seq_alu_sat(seq_alu_sat),
    .seq_alu_hc(seq_alu_hc), .seq_alu_sc(seq_alu_sc),
    .seq_xb_dtx(seq_xb_dtx), .seq_xb_dty(seq_xb_dty),
    .alu_seq_dt(alu_seq_dt), .alu_seq_az(alu_seq_az), .alu_seq_an(alu_seq_an),
    .alu_seq_ac(alu_seq_ac), .alu_seq_av(alu_seq_av),
    .seq_rf_we(seq_rf_we), .seq_rf_dt(seq_rf_dt), .seq_ps_astat(seq_ps_astat)
  );

  // Behavioural single-cycle ALU: ADD for opcode 0, otherwise subtract (SUB/COMP)
  logic [15:0] ax, ay;
  logic [5:0]  aop;
  logic        asat;
  always @(posedge clk) begin
    if (seq_alu_en) begin
      ax     <= seq_xb_dtx;
      ay     <= seq_xb_dty;
      aop    <= {seq_alu_log, seq_alu_hc, seq_alu_sc};
      asat   <= seq_alu_sat;
      en_cnt <= en_cnt + 1;
    end
  end

  always @* begin
    logic [16:0] s;
    logic        sub;
    sub = (aop != 6'b000000);
    if (sub) s = {1'b0, ax} + {1'b0, ~ay} + 17'd1;
    else     s = {1'b0, ax} + {1'b0, ay};
    alu_seq_ac = s[16];
    alu_seq_av = sub ? ((ax[15] != ay[15]) && (s[15] != ax[15]))
                     : ((ax[15] == ay[15]) && (s[15] != ax[15]));
    alu_seq_dt = (asat && alu_seq_av) ? (ax[15] ? 16'h8000 : 16'h7FFF) : s[15:0];
    alu_seq_az = (alu_seq_dt == 16'h0000);
    alu_seq_an = alu_seq_dt[15];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [5:0] op, input logic sat, input logic dbl, input logic clr,
                       input logic [31:0] x, input logic [31:0] y,
                       output int we_at, output logic [31:0] wd, output int pulses);
    int  en0;
    bit  done;
    @(negedge clk);
    {ps_seq_log, ps_seq_hc, ps_seq_sc} = op;
    ps_seq_sat = sat; ps_seq_dbl = dbl; ps_seq_x = x; ps_seq_y = y;
    ps_seq_clr_avs = clr;
    ps_seq_vld = 1'b1;
    en0 = en_cnt;
    @(posedge clk); #1;
    ps_seq_vld = 1'b0;
    we_at = -1; wd = '0; done = 0;
    for (int k = 1; k <= 12 && !done; k++) begin
      @(posedge clk); #1;
      if (seq_rf_we && we_at < 0) begin
        we_at = k;
        wd    = seq_rf_dt;
      end
      if (seq_ps_rdy) done = 1;
    end
    ps_seq_clr_avs = 1'b0;
    if (!done) check("op_timeout", 32'd0, 32'd1);
    pulses = en_cnt - en0;
  endtask

  initial begin
    int          we_at, pulses, we_seen;
    logic [31:0] wd;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",   {31'd0, seq_ps_rdy}, 32'd1);
    check("rst_en",    {31'd0, seq_alu_en}, 32'd0);
    check("rst_astat", {27'd0, seq_ps_astat}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single ADD 3 + 4
    do_op(6'b000000, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0004, we_at, wd, pulses);
    check("sadd_data",   wd, 32'h0000_0007);
    check("sadd_we_at",  we_at, 32'd2);
    check("sadd_pulses", pulses, 32'd1);
    check("sadd_astat",  {27'd0, seq_ps_astat}, 32'b00000);

    // Double ADD 0x0000FFFF + 1: carry forces FIX pass
    do_op(6'b000000, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, we_at, wd, pulses);
    check("dadd_data",   wd, 32'h0001_0000);
    check("dadd_pulses", pulses, 32'd3);
    check("dadd_we_at",  we_at, 32'd6);
    check("dadd_astat",  {27'd0, seq_ps_astat}, 32'b00000);

    // Double SUB 0x00010000 - 1: borrow forces FIX pass
    do_op(6'b000001, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0001, we_at, wd, pulses);
    check("dsub_data",   wd, 32'h0000_FFFF);
    check("dsub_pulses", pulses, 32'd3);
    check("dsub_astat",  {27'd0, seq_ps_astat}, 32'b00100);

    // Double SUB without borrow: two passes only, AC=1
    do_op(6'b000001, 1'b0, 1'b1, 1'b0, 32'h0003_0005, 32'h0001_0002, we_at, wd, pulses);
    check("dsub2_data",   wd, 32'h0002_0003);
    check("dsub2_pulses", pulses, 32'd2);
    check("dsub2_we_at",  we_at, 32'd4);

    // Double ADD overflow with sat request
    do_op(6'b000000, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, we_at, wd, pulses);
`ifdef ALU_SEQ_DBL_SAT_EN
    check("dovf_data",  wd, 32'h7FFF_FFFF);
`else
    check("dovf_data",  wd, 32'h8000_0000);
`endif
    check("dovf_astat", {27'd0, seq_ps_astat}, 32'b11010);

    // COMP 5 vs 5: flags only
    do_op(6'b000101, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0005, we_at, wd, pulses);
    check("comp_we_at", we_at, 32'hFFFF_FFFF);
    check("comp_astat", {27'd0, seq_ps_astat}, 32'b10101);

    // Single SUB 2 - 5 with dbl=1 on a logic op is not double: use plain SUB here
    do_op(6'b000001, 1'b0, 1'b0, 1'b0, 32'hAAAA_0002, 32'h5555_0005, we_at, wd, pulses);
    check("ssub_data",  wd, 32'h0000_FFFD);
    check("ssub_astat", {27'd0, seq_ps_astat}, 32'b10010);

    // Double flag on a non-ADD/SUB opcode is ignored: single pass
    do_op(6'b000010, 1'b0, 1'b1, 1'b0, 32'h1234_0009, 32'h4321_0001, we_at, wd, pulses);
    check("dign_pulses", pulses, 32'd1);
    check("dign_data",   wd, 32'h0000_0008);

    // Clear AVS while idle
    @(negedge clk); ps_seq_clr_avs = 1'b1;
    @(negedge clk); ps_seq_clr_avs = 1'b0;
    check("clr_avs", {31'd0, seq_ps_astat[4]}, 32'd0);

    // Clear coincident with an AV capture: set wins
    do_op(6'b000000, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, we_at, wd, pulses);
    check("avs_setwins", {31'd0, seq_ps_astat[4]}, 32'd1);

    // Reset during CAP_HI
    @(negedge clk);
    {ps_seq_log, ps_seq_hc, ps_seq_sc} = 6'b000000;
    ps_seq_dbl = 1'b1; ps_seq_sat = 1'b0;
    ps_seq_x = 32'h0000_FFFF; ps_seq_y = 32'h0000_0001;
    ps_seq_vld = 1'b1;
    @(posedge clk); #1; ps_seq_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("arst_rdy",   {31'd0, seq_ps_rdy}, 32'd1);
    check("arst_en",    {31'd0, seq_alu_en}, 32'd0);
    check("arst_we",    {31'd0, seq_rf_we}, 32'd0);
    check("arst_dt",    seq_rf_dt, 32'd0);
    check("arst_astat", {27'd0, seq_ps_astat}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    we_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (seq_rf_we) we_seen++;
    end
    check("arst_no_wb",  we_seen, 32'd0);
    check("arst_rdy_after", {31'd0, seq_ps_rdy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
